alu_arbiter: RTL and testbench

Shares the single combinational `alu` instance between two requesters: requester 0 is the execute stage, requester 1 is the branch/address helper. Each requester uses a valid/ready request channel and a valid/ready response channel. The block grants one request per cycle, drives the ALU control and operand inputs for that cycle, registers `alu_res`, and holds the result until the owning requester accepts it. The arbitration policy is selected at compile time.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch/address helper (requester 1). Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  // requester 0: execute stage
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [2:0]        req_funct3_0,
  input  logic [6:0]        req_funct7_0,
  input  logic              req_src_sel_0,
  input  logic [DATA_W-1:0] req_op_a_0,
  input  logic [DATA_W-1:0] req_op_b_0,
  input  logic [DATA_W-1:0] req_imm_0,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic [DATA_W-1:0] rsp_data_0,
  // requester 1: branch/address helper
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [2:0]        req_funct3_1,
  input  logic [6:0]        req_funct7_1,
  input  logic              req_src_sel_1,
  input  logic [DATA_W-1:0] req_op_a_1,
  input  logic [DATA_W-1:0] req_op_b_1,
  input  logic [DATA_W-1:0] req_imm_1,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_data_1,
  // shared ALU
  output logic              alu_en,
  output logic [2:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic              alu_src_sel,
  output logic [DATA_W-1:0] alu_reg_data_1,
  output logic [DATA_W-1:0] alu_reg_data_2,
  output logic [DATA_W-1:0] alu_immediate,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_data;

  logic w_busy;
  logic w_rsp_take;
  logic w_can_issue;
  logic w_tie_pick;
  logic w_grant;
  logic w_issue;
  logic w_out_en;

  assign w_busy      = (r_state == S_RESP);
  assign w_rsp_take  = w_busy & (r_owner ? rsp_ready_1 : rsp_ready_0);
  // Retire and issue may share a cycle, which is what gives back-to-back throughput.
  assign w_can_issue = ~flush & (~w_busy | w_rsp_take);
  assign w_tie_pick  = RR_EN & ~r_last_grant;
  assign w_grant     = req_valid_1 & (~req_valid_0 | w_tie_pick);
  assign w_issue     = w_can_issue & (req_valid_0 | req_valid_1);
  // Outputs must read 0 while reset is held, even with requests present.
  assign w_out_en    = rst_n & w_issue;

  assign req_ready_0 = w_out_en & ~w_grant;
  assign req_ready_1 = w_out_en &  w_grant;
  assign alu_en      = w_out_en;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    alu_funct3     = '0;
    alu_funct7     = '0;
    alu_src_sel    = 1'b0;
    alu_reg_data_1 = '0;
    alu_reg_data_2 = '0;
    alu_immediate  = '0;
    if (w_out_en) begin
      if (w_grant) begin
        alu_funct3     = req_funct3_1;
        alu_funct7     = req_funct7_1;
        alu_src_sel    = req_src_sel_1;
        alu_reg_data_1 = req_op_a_1;
        alu_reg_data_2 = req_op_b_1;
        alu_immediate  = req_imm_1;
      end else begin
        alu_funct3     = req_funct3_0;
        alu_funct7     = req_funct7_0;
        alu_src_sel    = req_src_sel_0;
        alu_reg_data_1 = req_op_a_0;
        alu_reg_data_2 = req_op_b_0;
        alu_immediate  = req_imm_0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_data       <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (w_issue) begin
      r_state      <= S_RESP;
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
      r_data       <= alu_res;
    end else if (w_rsp_take) begin
      r_state <= S_IDLE;
    end
  end

  assign busy        = w_busy;
  assign rsp_valid_0 = w_busy & ~r_owner;
  assign rsp_valid_1 = w_busy &  r_owner;
  assign rsp_data_0  = rsp_valid_0 ? r_data : '0;
  assign rsp_data_1  = rsp_valid_1 ? r_data : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } req_t;

  logic clk, rst_n, flush;
  logic req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
  logic req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
  logic [31:0] rsp_data_0, rsp_data_1;
  req_t rq0, rq1;
  logic alu_en, alu_src_sel, busy;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_reg_data_1, alu_reg_data_2, alu_immediate, alu_res;

  int checks = 0;
  int errors = 0;

  // transaction-level model: one pending response slot plus tie history
  logic        m_busy, m_owner, m_last;
  logic [31:0] m_data;
  logic        acc0, acc1;

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_funct3, alu_funct7, alu_reg_data_1,
                           alu_src_sel ? alu_reg_data_2 : alu_immediate);

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_funct3_0(rq0.f3), .req_funct7_0(rq0.f7), .req_src_sel_0(rq0.src),
    .req_op_a_0(rq0.a), .req_op_b_0(rq0.b), .req_imm_0(rq0.imm),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_data_0(rsp_data_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_funct3_1(rq1.f3), .req_funct7_1(rq1.f7), .req_src_sel_1(rq1.src),
    .req_op_a_1(rq1.a), .req_op_b_1(rq1.b), .req_imm_1(rq1.imm),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
    .alu_en(alu_en), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_src_sel(alu_src_sel), .alu_reg_data_1(alu_reg_data_1),
    .alu_reg_data_2(alu_reg_data_2), .alu_immediate(alu_immediate),
    .alu_res(alu_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic [2:0] f3, input logic [6:0] f7, input logic src,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    req_t r;
    r.f3 = f3; r.f7 = f7; r.src = src; r.a = a; r.b = b; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req(3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                  1'($urandom), $urandom, $urandom, $urandom);
  endfunction

  function automatic logic [31:0] result_of(input req_t r);
    return alu_ref(r.f3, r.f7, r.a, r.src ? r.b : r.imm);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; checks the cycle, then advances it.
  task automatic step();
    logic retire, may_issue, g, issue;
    req_t r;
    #1;
    retire    = m_busy && (m_owner ? rsp_ready_1 : rsp_ready_0);
    may_issue = !flush && (!m_busy || retire);
    if (req_valid_0 && req_valid_1) g = RR ? !m_last : 1'b0;
    else                            g = req_valid_1;
    issue = may_issue && (req_valid_0 || req_valid_1);
    r = g ? rq1 : rq0;
    check("req_ready_0", {31'd0, req_ready_0}, {31'd0, issue && !g});
    check("req_ready_1", {31'd0, req_ready_1}, {31'd0, issue && g});
    check("alu_en", {31'd0, alu_en}, {31'd0, issue});
    check("alu_funct3", {29'd0, alu_funct3}, issue ? {29'd0, r.f3} : 32'd0);
    check("alu_funct7", {25'd0, alu_funct7}, issue ? {25'd0, r.f7} : 32'd0);
    check("alu_src_sel", {31'd0, alu_src_sel}, issue ? {31'd0, r.src} : 32'd0);
    check("alu_reg_data_1", alu_reg_data_1, issue ? r.a : 32'd0);
    check("alu_reg_data_2", alu_reg_data_2, issue ? r.b : 32'd0);
    check("alu_immediate", alu_immediate, issue ? r.imm : 32'd0);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("rsp_valid_0", {31'd0, rsp_valid_0}, {31'd0, m_busy && !m_owner});
    check("rsp_valid_1", {31'd0, rsp_valid_1}, {31'd0, m_busy && m_owner});
    check("rsp_data_0", rsp_data_0, (m_busy && !m_owner) ? m_data : 32'd0);
    check("rsp_data_1", rsp_data_1, (m_busy && m_owner) ? m_data : 32'd0);
    acc0 = issue && !g;
    acc1 = issue && g;
    @(posedge clk);
    if (flush) begin
      m_busy = 1'b0;
    end else if (issue) begin
      m_busy = 1'b1; m_owner = g; m_last = g; m_data = result_of(r);
    end else if (retire) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (acc0) req_valid_0 = 1'b0;
      if (acc1) req_valid_1 = 1'b0;
      step();
    end
  endtask

  initial begin
    int n1;
    rst_n = 1'b0; flush = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    rq0 = rand_req(); rq1 = rand_req();
    model_reset();

    // reset state, with requests present
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_ready_0", {31'd0, req_ready_0}, 32'd0);
    check("rst_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_alu_reg_data_1", alu_reg_data_1, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
    check("rst_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rst_n = 1'b1;

    // single ADD 5+7
    rq0 = mk_req(3'd0, 7'h00, 1'b1, 32'd5, 32'd7, 32'd0);
    req_valid_0 = 1'b1; #1;
    check("t1_req_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("t1_alu_en", {31'd0, alu_en}, 32'd1);
    step();
    req_valid_0 = 1'b0; #1;
    check("t1_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
    check("t1_rsp_data_0", rsp_data_0, 32'd12);
    check("t1_busy", {31'd0, busy}, 32'd1);
    rsp_ready_0 = 1'b1;
    step();

    // backpressure after ADD 1+1
    rq0 = mk_req(3'd0, 7'h00, 1'b1, 32'd1, 32'd1, 32'd0);
    req_valid_0 = 1'b1;
    step();
    rq0 = mk_req(3'd0, 7'h20, 1'b0, 32'd50, 32'd0, 32'd8);
    rq1 = mk_req(3'd4, 7'h00, 1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0);
    req_valid_1 = 1'b1; rsp_ready_0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_hold_data", rsp_data_0, 32'd2);
      check("t4_ready_0", {31'd0, req_ready_0}, 32'd0);
      check("t4_ready_1", {31'd0, req_ready_1}, 32'd0);
      check("t4_alu_en", {31'd0, alu_en}, 32'd0);
      step();
    end
    rsp_ready_0 = 1'b1; #1;
    check("t4_resume_alu_en", {31'd0, alu_en}, 32'd1);
    step();
    drain();

    // flush while requester 1 holds a response and requester 0 waits
    rq1 = mk_req(3'd6, 7'h00, 1'b0, 32'h0000_000F, 32'd0, 32'h0000_00F0);
    req_valid_1 = 1'b1; rsp_ready_1 = 1'b0;
    step();
    req_valid_1 = 1'b0;
    rq0 = mk_req(3'd1, 7'h00, 1'b0, 32'd3, 32'd0, 32'd4);
    req_valid_0 = 1'b1; flush = 1'b1; #1;
    check("t5_pre_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("t5_flush_alu_en", {31'd0, alu_en}, 32'd0);
    check("t5_flush_ready_0", {31'd0, req_ready_0}, 32'd0);
    step();
    flush = 1'b0; #1;
    check("t5_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ready_0", {31'd0, req_ready_0}, 32'd1);
    step();

    // sustained tie, responses always taken
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    if (acc0) rq0 = rand_req();
    rq1 = rand_req(); req_valid_1 = 1'b1;
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n1 += int'(req_ready_1);
`ifndef ALU_ARB_ROUND_ROBIN_EN
      check("t3_starve_ready_1", {31'd0, req_ready_1}, 32'd0);
`endif
      step();
      if (acc0) rq0 = rand_req();
      if (acc1) rq1 = rand_req();
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    check("t3_rr_grants_1", 32'(n1), 32'd10);
`endif
    drain();

    // reset with a response pending, then the first tie after release
    rq0 = mk_req(3'd0, 7'h00, 1'b1, 32'd3, 32'd4, 32'd0);
    req_valid_0 = 1'b1; rsp_ready_0 = 1'b0;
    step();
    rq0 = mk_req(3'd0, 7'h20, 1'b1, 32'd10, 32'd3, 32'd0);
    rq1 = mk_req(3'd7, 7'h00, 1'b1, 32'h0000_00F0, 32'h0000_003C, 32'd0);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
    check("t6_rsp_data_0", rsp_data_0, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_alu_en", {31'd0, alu_en}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1; #1;
    check("t6_tie_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("t6_tie_ready_1", {31'd0, req_ready_1}, 32'd0);
    step();
    req_valid_0 = 1'b0; #1;
    check("t2_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
    check("t2_rsp_data_0", rsp_data_0, 32'd7);
    check("t2_ready_1", {31'd0, req_ready_1}, 32'd1);
    step();
    req_valid_1 = 1'b0; #1;
    check("t2_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("t2_rsp_data_1", rsp_data_1, 32'h0000_0030);
    step();

    // random traffic; a request stays put until the model says it was accepted
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!req_valid_0 || acc0) begin
        req_valid_0 = ($urandom_range(0, 3) != 0);
        rq0 = rand_req();
      end
      if (!req_valid_1 || acc1) begin
        req_valid_1 = ($urandom_range(0, 3) != 0);
        rq1 = rand_req();
      end
      rsp_ready_0 = ($urandom_range(0, 3) != 0);
      rsp_ready_1 = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
